// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the multi-cycle divider.
// Holds the divider state encoding and its fixed start-to-done latency.
package mips_pkg;

  localparam int DIV_CYCLES = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } div_state_t;

endpackage

// File: rtl/add.sv
// Ripple-style adder with carry in/out.
// The divider uses it as a subtractor by passing an inverted operand and cin=1.
module add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU.
// Quotient feeds LO, remainder feeds HI; busy stalls the pipeline while dividing.
module div_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return '0 - x;
  endfunction

  div_state_t       state;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             qsign;
  logic             rsign;
  logic             div0;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] t;
  logic             cout;
  logic             ge;

  // The partial remainder is always < D after a step, so its top bit only
  // exists transiently in the shifted value p_sh and need not be stored.
  assign p_sh = {p, q[WIDTH-1]};

  add #(.WIDTH(WIDTH)) u_add (
    .a    (p_sh[WIDTH-1:0]),
    .b    (~d),
    .cin  (1'b1),
    .sum  (t),
    .cout (cout)
  );

  assign ge = p_sh[WIDTH] | cout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      div0        <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q     <= (is_signed && dividend[WIDTH-1]) ? neg(dividend) : dividend;
            d     <= (is_signed && divisor[WIDTH-1])  ? neg(divisor)  : divisor;
            qsign <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rsign <= is_signed & dividend[WIDTH-1];
            div0  <= (divisor == '0);
            p     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          q   <= {q[WIDTH-2:0], ge};
          p   <= ge ? t : p_sh[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= SIGN;
        end
        SIGN: begin
          // A zero divisor leaves P = |dividend|, so the rsign fix restores the raw dividend
          quotient    <= div0 ? '1 : (qsign ? neg(q) : q);
          remainder   <= rsign ? neg(p) : p;
          done        <= 1'b1;
          div_by_zero <= div0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued at issue time
// and compared when done pulses, along with latency and control behaviour.
module tb_div_seq;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          sc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_sc = 0;
  logic prev_done = 1'b0;

  div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa, sb_;
    e.sc = 0;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      sa  = a;
      sb_ = b;
      e.q = sa / sb_;
      e.r = sa % sb_;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Result checker: every done must match the oldest outstanding request
  always @(negedge clk) begin : mon
    exp_t e;
    if (prev_done) begin
      check("done_single_pulse", {31'd0, done}, 32'd0);
      check("dz_after_done", {31'd0, div_by_zero}, 32'd0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        check("latency", cyc - e.sc, DIV_CYCLES);
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done <= done;
  end

  // Drive start during the current cycle (caller is at a negedge)
  task automatic issue_now(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(s, a, b);
    e.sc = cyc;
    last_sc = cyc;
    sb.push_back(e);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(s, a, b);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 100 && cyc < c; i++) @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_dz"}, {31'd0, div_by_zero}, 32'd0);
    check({tag, "_quotient"}, quotient, 32'd0);
    check({tag, "_remainder"}, remainder, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    issue(1'b0, 32'd100, 32'd7);
    wait_done();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done();
    issue(1'b1, 32'd5, 32'd0);
    wait_done();
    // Start in the done cycle is accepted immediately
    issue_now(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue(1'b0, 32'd0, 32'd0);
    wait_done();
    issue(1'b1, 32'hFFFF_FFF0, 32'd0);
    wait_done();
    issue(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_done();

    // A second start while busy must be dropped
    issue(1'b0, 32'd1000, 32'd10);
    wait_until(last_sc + 10);
    is_signed = 1'b1;
    dividend  = 32'd77;
    divisor   = 32'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(1'(i % 3 == 0), a, b);
      wait_done();
    end
    repeat (40) @(negedge clk);

    // Reset mid-divide aborts with no done
    issue(1'b1, 32'd12345, 32'hFFFF_FFFD);
    wait_until(last_sc + 20);
    rst_n = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check_cleared("abort");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue(1'b0, 32'd9, 32'd4);
    wait_done();
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
